// File: rtl/vis_pkg.sv
// vis_pkg: shared definitions for the vis_* video blocks.
//   mode_e      overlay mode encoding (pass, full crosshair, short cross, box)
//   OBJ_COLOUR  per-object marker colour, RGB888
//   XW / YW     raster coordinate widths
//   near12 / within12  12-bit distance helpers; the spare top bit keeps
//                      +THICK / -c from wrapping at either image edge
package vis_pkg;

    localparam int XW = 11;
    localparam int YW = 10;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_CROSS = 2'd1,
        MODE_SHORT = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    localparam logic [23:0] OBJ_COLOUR [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00};

    // |p - c| <= t, written without subtraction so 0 - t cannot underflow
    function automatic logic near12(input logic [11:0] p, input logic [11:0] c,
                                    input logic [11:0] t);
        return ((p + t) >= c) && (p <= (c + t));
    endfunction

    function automatic logic within12(input logic [11:0] p, input logic [11:0] c,
                                      input logic [11:0] arm);
        logic [11:0] d;
        d = (p >= c) ? (p - c) : (c - p);
        return d <= arm;
    endfunction

endpackage

// File: rtl/vis_pos_counter.sv
// vis_pos_counter: raster position tracker shared by vis_* blocks.
//   clk, rst      pixel clock, async active-high reset
//   de, vsync     data enable, vertical sync (active-high)
//   x_pos, y_pos  coordinate of the pixel currently presented on de
//   sof           one-cycle pulse on the first vsync=1 cycle of a frame
module vis_pos_counter
    import vis_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de,
    input  logic          vsync,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          sof
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          vsync_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        // vsync wins over de, so a frame cut short mid-line starts clean
        if (vsync) begin
            x_d = '0;
            y_d = '0;
        end else if (de) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            vsync_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vsync_q <= vsync;
        end
    end

    assign x_pos = x_q;
    assign y_pos = y_q;
    assign sof   = vsync & ~vsync_q;

endmodule

// File: rtl/vis_overlay_multi.sv
// vis_overlay_multi: draws per-object markers over an RGB888 stream.
//   clk, rst                   pixel clock, async active-high reset
//   de, vsync, hsync, pixel_in input video
//   xcent/ycent                object centroids, 11/10 bits per object
//   xmin/xmax/ymin/ymax        object bounding boxes, same packing
//   obj_valid, mode            object present flags, overlay mode
//   pixel_out, *_out           overlaid video, two cycles behind the input
// Geometry, valid flags and mode are shadowed at frame start so a frame is
// always drawn from one consistent set of values.
module vis_overlay_multi
    import vis_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720,
    parameter int N_OBJ = 2,
    parameter int THICK = 0,
    parameter int ARM   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  de,
    input  logic                  vsync,
    input  logic                  hsync,
    input  logic [23:0]           pixel_in,
    input  logic [XW*N_OBJ-1:0]   xcent,
    input  logic [YW*N_OBJ-1:0]   ycent,
    input  logic [XW*N_OBJ-1:0]   xmin,
    input  logic [XW*N_OBJ-1:0]   xmax,
    input  logic [YW*N_OBJ-1:0]   ymin,
    input  logic [YW*N_OBJ-1:0]   ymax,
    input  logic [N_OBJ-1:0]      obj_valid,
    input  logic [1:0]            mode,
    output logic [23:0]           pixel_out,
    output logic                  de_out,
    output logic                  vsync_out,
    output logic                  hsync_out
);

    localparam logic [11:0] T12 = 12'(THICK);
    localparam logic [11:0] A12 = 12'(ARM);

    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic          sof;

    vis_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
        .clk   (clk),
        .rst   (rst),
        .de    (de),
        .vsync (vsync),
        .x_pos (x_pos),
        .y_pos (y_pos),
        .sof   (sof)
    );

    logic [XW*N_OBJ-1:0] sh_xc_q, sh_x0_q, sh_x1_q;
    logic [YW*N_OBJ-1:0] sh_yc_q, sh_y0_q, sh_y1_q;
    logic [N_OBJ-1:0]    sh_valid_q;
    mode_e               sh_mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_xc_q    <= '0;
            sh_x0_q    <= '0;
            sh_x1_q    <= '0;
            sh_yc_q    <= '0;
            sh_y0_q    <= '0;
            sh_y1_q    <= '0;
            sh_valid_q <= '0;
            sh_mode_q  <= MODE_PASS;
        end else if (sof) begin
            sh_xc_q    <= xcent;
            sh_x0_q    <= xmin;
            sh_x1_q    <= xmax;
            sh_yc_q    <= ycent;
            sh_y0_q    <= ymin;
            sh_y1_q    <= ymax;
            sh_valid_q <= obj_valid;
            sh_mode_q  <= mode_e'(mode);
        end
    end

    logic [11:0]      px, py;
    logic [N_OBJ-1:0] hit_d;

    assign px = {1'b0, x_pos};
    assign py = {2'b00, y_pos};

    for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
        logic [11:0] xc, yc, x0, x1, y0, y1;
        logic        nx_c, ny_c, cross_hit, short_hit, box_hit, sel;

        assign xc = {1'b0, sh_xc_q[k*XW +: XW]};
        assign x0 = {1'b0, sh_x0_q[k*XW +: XW]};
        assign x1 = {1'b0, sh_x1_q[k*XW +: XW]};
        assign yc = {2'b00, sh_yc_q[k*YW +: YW]};
        assign y0 = {2'b00, sh_y0_q[k*YW +: YW]};
        assign y1 = {2'b00, sh_y1_q[k*YW +: YW]};

        assign nx_c      = near12(px, xc, T12);
        assign ny_c      = near12(py, yc, T12);
        assign cross_hit = nx_c | ny_c;
        assign short_hit = (nx_c & within12(py, yc, A12)) | (ny_c & within12(px, xc, A12));
        // an inverted box is treated as empty rather than as a wrapped outline
        assign box_hit   = (x0 <= x1) && (y0 <= y1) &&
                           (((near12(px, x0, T12) || near12(px, x1, T12)) && (py >= y0) && (py <= y1)) ||
                            ((near12(py, y0, T12) || near12(py, y1, T12)) && (px >= x0) && (px <= x1)));

        always_comb begin
            sel = 1'b0;
            unique case (sh_mode_q)
                MODE_CROSS: sel = cross_hit;
                MODE_SHORT: sel = short_hit;
                MODE_BOX:   sel = box_hit;
                default:    sel = 1'b0;
            endcase
        end

        // blanking cycles sit outside the image; the counter holds a stale
        // coordinate there, so hits are gated by de
        assign hit_d[k] = de & sh_valid_q[k] & sel;
    end

    logic [N_OBJ-1:0] hit_q;
    logic [23:0]      pix1_q, pix2_q, col_d;
    logic             de1_q, vs1_q, hs1_q, de2_q, vs2_q, hs2_q;

    always_comb begin
        col_d = pix1_q;
        // walk downwards so the lowest-index hit is the last (winning) write
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (hit_q[k]) col_d = OBJ_COLOUR[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            pix1_q <= '0;
            de1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            pix2_q <= '0;
            de2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            hs2_q  <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            pix1_q <= pixel_in;
            de1_q  <= de;
            vs1_q  <= vsync;
            hs1_q  <= hsync;
            pix2_q <= col_d;
            de2_q  <= de1_q;
            vs2_q  <= vs1_q;
            hs2_q  <= hs1_q;
        end
    end

    assign pixel_out = pix2_q;
    assign de_out    = de2_q;
    assign vsync_out = vs2_q;
    assign hsync_out = hs2_q;

endmodule

// File: tb/tb_vis_overlay_multi.sv
// Bench for vis_overlay_multi on a reduced 64x32 raster. The stimulus side
// knows each pixel's coordinate from its own frame loops and pushes the
// expected output tuple; the monitor pops and compares two cycles later.
module tb_vis_overlay_multi;

    localparam int W      = 64;
    localparam int H      = 32;
    localparam int N      = 2;
    localparam int TH     = 1;
    localparam int ARMP   = 16;
    localparam int HBLANK = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          de = 1'b0, vsync = 1'b0, hsync = 1'b0;
    logic [23:0]   pixel_in = '0;
    logic [21:0]   xcent = '0, xmin = '0, xmax = '0;
    logic [19:0]   ycent = '0, ymin = '0, ymax = '0;
    logic [1:0]    obj_valid = '0;
    logic [1:0]    mode = '0;
    logic [23:0]   pixel_out;
    logic          de_out, vsync_out, hsync_out;

    vis_overlay_multi #(.IMG_W(W), .IMG_H(H), .N_OBJ(N), .THICK(TH), .ARM(ARMP)) dut (
        .clk       (clk),
        .rst       (rst),
        .de        (de),
        .vsync     (vsync),
        .hsync     (hsync),
        .pixel_in  (pixel_in),
        .xcent     (xcent),
        .ycent     (ycent),
        .xmin      (xmin),
        .xmax      (xmax),
        .ymin      (ymin),
        .ymax      (ymax),
        .obj_valid (obj_valid),
        .mode      (mode),
        .pixel_out (pixel_out),
        .de_out    (de_out),
        .vsync_out (vsync_out),
        .hsync_out (hsync_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        vs;
        logic        hs;
        logic [23:0] px;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // bench copy of the per-frame object state
    int   s_xc[N], s_yc[N], s_x0[N], s_x1[N], s_y0[N], s_y1[N];
    bit   s_val[N];
    int   s_mode = 0;
    logic prev_vs = 1'b0;
    bit   rel_pending = 1'b0;

    function automatic bit near(int p, int c);
        return (p - c <= TH) && (c - p <= TH);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [23:0] colour(int k);
        case (k)
            0:       return 24'hFF0000;
            1:       return 24'h00FF00;
            2:       return 24'h0000FF;
            default: return 24'hFFFF00;
        endcase
    endfunction

    function automatic bit obj_hit(int k, int x, int y);
        if (!s_val[k]) return 1'b0;
        case (s_mode)
            1: return near(x, s_xc[k]) || near(y, s_yc[k]);
            2: return (near(x, s_xc[k]) && iabs(y - s_yc[k]) <= ARMP) ||
                      (near(y, s_yc[k]) && iabs(x - s_xc[k]) <= ARMP);
            3: begin
                if (s_x0[k] > s_x1[k] || s_y0[k] > s_y1[k]) return 1'b0;
                return ((near(x, s_x0[k]) || near(x, s_x1[k])) && y >= s_y0[k] && y <= s_y1[k]) ||
                       ((near(y, s_y0[k]) || near(y, s_y1[k])) && x >= s_x0[k] && x <= s_x1[k]);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic d, input logic vs, input logic hs, input int x, input int y);
        exp_t        e;
        logic [23:0] pix;
        @(negedge clk);
        if (rel_pending) begin
            rst         = 1'b0;
            rel_pending = 1'b0;
        end
        pix      = 24'($urandom);
        de       = d;
        vsync    = vs;
        hsync    = hs;
        pixel_in = pix;
        if (rst) begin
            e = '0;
        end else begin
            if (vs && !prev_vs) begin
                for (int k = 0; k < N; k++) begin
                    s_xc[k]  = int'(xcent[11*k +: 11]);
                    s_x0[k]  = int'(xmin[11*k +: 11]);
                    s_x1[k]  = int'(xmax[11*k +: 11]);
                    s_yc[k]  = int'(ycent[10*k +: 10]);
                    s_y0[k]  = int'(ymin[10*k +: 10]);
                    s_y1[k]  = int'(ymax[10*k +: 10]);
                    s_val[k] = obj_valid[k];
                end
                s_mode = int'(mode);
            end
            e.de = d;
            e.vs = vs;
            e.hs = hs;
            e.px = pix;
            if (d) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (obj_hit(k, x, y)) e.px = colour(k);
                end
            end
        end
        prev_vs = rst ? 1'b0 : vs;
        q.push_back(e);
    endtask

    // asserts reset at a falling edge for n rising edges; anything already in
    // the pipeline is wiped, so queued expectations become all-zero
    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        de       = 1'b0;
        vsync    = 1'b0;
        hsync    = 1'b0;
        pixel_in = '0;
        #1;
        checks++;
        if ({de_out, vsync_out, hsync_out, pixel_out} !== 27'd0) begin
            errors++;
            $display("FAIL reset_state t=%0t got de=%b vs=%b hs=%b px=%h expected all zero",
                     $time, de_out, vsync_out, hsync_out, pixel_out);
        end
        foreach (q[i]) q[i] = '0;
        for (int k = 0; k < N; k++) s_val[k] = 1'b0;
        s_mode  = 0;
        prev_vs = 1'b0;
        q.push_back('0);
        repeat (n - 1) drive(1'b0, 1'b0, 1'b0, 0, 0);
        rel_pending = 1'b1;
    endtask

    task automatic set_obj(input int k, input int xc, input int yc, input int x0, input int x1,
                           input int y0, input int y1, input bit v);
        xcent[11*k +: 11] = 11'(xc);
        xmin[11*k +: 11]  = 11'(x0);
        xmax[11*k +: 11]  = 11'(x1);
        ycent[10*k +: 10] = 10'(yc);
        ymin[10*k +: 10]  = 10'(y0);
        ymax[10*k +: 10]  = 10'(y1);
        obj_valid[k]      = v;
    endtask

    // stop_y/stop_x cut the frame short before that pixel; chg_y moves
    // object 0's centroid column to chg_x at the start of that line
    task automatic run_frame(input bit with_vs, input int stop_y, input int stop_x,
                             input int chg_y, input int chg_x);
        if (with_vs) begin
            repeat (3) drive(1'b0, 1'b1, 1'b0, 0, 0);
            repeat (2) drive(1'b0, 1'b0, 1'b0, 0, 0);
        end
        for (int y = 0; y < H; y++) begin
            if (y == chg_y) xcent[10:0] = 11'(chg_x);
            for (int x = 0; x < W; x++) begin
                if (y == stop_y && x == stop_x) return;
                drive(1'b1, 1'b0, 1'b0, x, y);
            end
            for (int b = 0; b < HBLANK; b++) drive(1'b0, 1'b0, (b >= 2 && b < 5), 0, 0);
        end
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() >= 2) begin
                e = q.pop_front();
                checks++;
                if ({de_out, vsync_out, hsync_out, pixel_out} !== e) begin
                    errors++;
                    $display("FAIL out_tuple t=%0t got de=%b vs=%b hs=%b px=%h expected de=%b vs=%b hs=%b px=%h",
                             $time, de_out, vsync_out, hsync_out, pixel_out, e.de, e.vs, e.hs, e.px);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL timeout t=%0t stimulus did not complete", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        do_reset(3);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 0, 0);

        // full crosshairs, obj0 wins where lines cross
        mode = 2'd1;
        set_obj(0, 32, 16, 0, 0, 0, 0, 1'b1);
        set_obj(1, 10, 5, 0, 0, 0, 0, 1'b1);
        run_frame(1'b1, -1, -1, -1, 0);

        // short cross at the origin, obj1 present but not valid
        mode = 2'd2;
        set_obj(0, 0, 0, 0, 0, 0, 0, 1'b1);
        set_obj(1, 40, 20, 0, 0, 0, 0, 1'b0);
        run_frame(1'b1, -1, -1, -1, 0);

        // boxes: a normal one and an inverted one
        mode = 2'd3;
        set_obj(0, 0, 0, 10, 20, 5, 12, 1'b1);
        set_obj(1, 0, 0, 30, 25, 3, 9, 1'b1);
        run_frame(1'b1, -1, -1, -1, 0);

        // centroid moved mid-frame only lands on the following frame
        mode = 2'd1;
        set_obj(0, 32, 16, 0, 0, 0, 0, 1'b1);
        set_obj(1, 10, 5, 0, 0, 0, 0, 1'b0);
        run_frame(1'b1, -1, -1, 10, 50);
        run_frame(1'b1, -1, -1, -1, 0);

        // vsync arriving mid-line
        set_obj(1, 10, 5, 0, 0, 0, 0, 1'b1);
        run_frame(1'b1, 5, 20, -1, 0);
        run_frame(1'b1, -1, -1, -1, 0);

        // reset mid-frame, pass-through until the next frame start
        run_frame(1'b1, 8, 10, -1, 0);
        do_reset(3);
        run_frame(1'b0, 6, 0, -1, 0);
        run_frame(1'b1, -1, -1, -1, 0);

        // mode 0, then mode 1 with no valid objects
        mode = 2'd0;
        run_frame(1'b1, -1, -1, -1, 0);
        mode = 2'd1;
        set_obj(0, 32, 16, 0, 0, 0, 0, 1'b0);
        set_obj(1, 10, 5, 0, 0, 0, 0, 1'b0);
        run_frame(1'b1, -1, -1, -1, 0);

        repeat (4) drive(1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
